// File: rtl/ps2_pkg.sv
// Shared constants, FSM state encoding and helpers for the PS/2 keyboard transmit path.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT     = 8'h12;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_ERR,
        S_FRAME,
        S_GAP
    } ps2_state_t;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h5A);
    endfunction

endpackage

// File: rtl/ascii_to_ps2.sv
// Combinational ASCII -> PS/2 Set-2 make-code lookup (inverse of the receive decode table).
// With PS2_TX_SHIFT_EN defined, A-Z fold onto their lowercase codes.
module ascii_to_ps2
    import ps2_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [7:0] code,
    output logic       hit
);

    logic [7:0] key;

    always_comb begin
`ifdef PS2_TX_SHIFT_EN
        key = is_upper(ascii) ? (ascii | 8'h20) : ascii;
`else
        key = ascii;
`endif
        code = '0;
        hit  = 1'b1;
        case (key)
            8'h61: code = 8'h1C;  8'h62: code = 8'h32;  8'h63: code = 8'h21;
            8'h64: code = 8'h23;  8'h65: code = 8'h24;  8'h66: code = 8'h2B;
            8'h67: code = 8'h34;  8'h68: code = 8'h33;  8'h69: code = 8'h43;
            8'h6A: code = 8'h3B;  8'h6B: code = 8'h42;  8'h6C: code = 8'h4B;
            8'h6D: code = 8'h3A;  8'h6E: code = 8'h31;  8'h6F: code = 8'h44;
            8'h70: code = 8'h4D;  8'h71: code = 8'h15;  8'h72: code = 8'h2D;
            8'h73: code = 8'h1B;  8'h74: code = 8'h2C;  8'h75: code = 8'h3C;
            8'h76: code = 8'h2A;  8'h77: code = 8'h1D;  8'h78: code = 8'h22;
            8'h79: code = 8'h35;  8'h7A: code = 8'h1A;
            8'h30: code = 8'h45;  8'h31: code = 8'h16;  8'h32: code = 8'h1E;
            8'h33: code = 8'h26;  8'h34: code = 8'h25;  8'h35: code = 8'h2E;
            8'h36: code = 8'h36;  8'h37: code = 8'h3D;  8'h38: code = 8'h3E;
            8'h39: code = 8'h46;
            8'h20: code = 8'h29;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// PS/2 keyboard emulator: ASCII in over valid/ready, make/break scan-code frames out.
// Optional PS2_TX_SHIFT_EN: uppercase letters are wrapped in left-shift make/break.
module ps2_keyboard_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_ascii,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       err
);

`ifdef PS2_TX_SHIFT_EN
    localparam int SEQ_LEN = 6;
`else
    localparam int SEQ_LEN = 3;
`endif
    localparam int HALF_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W  = $clog2(PS2_FRAME_BITS);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int BYTE_W = $clog2(SEQ_LEN + 1);

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_FALL = HALF_W'(CLK_DIV);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PS2_FRAME_BITS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    ps2_state_t state, state_nx;

    logic [7:0]        ascii_q, code_q, lut_code, cur_byte;
    logic              lut_hit, accept, frame_done, gap_done;
    logic [HALF_W-1:0] half_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [BYTE_W-1:0] byte_idx, byte_last;
    logic [10:0]       frame_vec;
`ifdef PS2_TX_SHIFT_EN
    logic              shift_q;
`endif

    ascii_to_ps2 u_lut (
        .ascii (ascii_q),
        .code  (lut_code),
        .hit   (lut_hit)
    );

    assign in_ready   = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign err        = (state == S_ERR);
    assign accept     = in_valid & in_ready;
    assign frame_done = (state == S_FRAME) && (bit_cnt == BIT_LAST) && (half_cnt == HALF_LAST);
    assign gap_done   = (state == S_GAP) && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = S_LOOKUP;
            S_LOOKUP: state_nx = lut_hit ? S_FRAME : S_ERR;
            S_ERR:    state_nx = S_IDLE;
            S_FRAME:  if (frame_done) state_nx = S_GAP;
            S_GAP:    if (gap_done) state_nx = (byte_idx == byte_last) ? S_IDLE : S_FRAME;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ascii_q  <= '0;
            code_q   <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            byte_idx <= '0;
`ifdef PS2_TX_SHIFT_EN
            shift_q  <= 1'b0;
`endif
        end else begin
            if (accept) ascii_q <= in_ascii;
            case (state)
                S_LOOKUP: begin
                    code_q   <= lut_code;
                    half_cnt <= '0;
                    bit_cnt  <= '0;
                    gap_cnt  <= '0;
                    byte_idx <= '0;
`ifdef PS2_TX_SHIFT_EN
                    shift_q  <= is_upper(ascii_q);
`endif
                end
                S_FRAME: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        bit_cnt  <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                    gap_cnt <= '0;
                end
                S_GAP: begin
                    if (gap_done) begin
                        gap_cnt  <= '0;
                        byte_idx <= byte_idx + 1'b1;
                    end else begin
                        gap_cnt  <= gap_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte currently on the wire, selected by position in the make/break sequence.
    always_comb begin
        cur_byte  = code_q;
        byte_last = BYTE_W'(2);
`ifdef PS2_TX_SHIFT_EN
        if (shift_q) begin
            byte_last = BYTE_W'(5);
            case (byte_idx)
                BYTE_W'(0), BYTE_W'(5): cur_byte = PS2_LSHIFT;
                BYTE_W'(2), BYTE_W'(4): cur_byte = PS2_BREAK;
                default:                cur_byte = code_q;
            endcase
        end else if (byte_idx == BYTE_W'(1)) begin
            cur_byte = PS2_BREAK;
        end
`else
        if (byte_idx == BYTE_W'(1)) cur_byte = PS2_BREAK;
`endif
    end

    // stop, odd parity, data LSB-first, start
    assign frame_vec = {1'b1, ~^cur_byte, cur_byte, 1'b0};

    assign ps2_clk  = (state != S_FRAME) || (half_cnt < HALF_FALL);
    assign ps2_data = (state != S_FRAME) || frame_vec[bit_cnt];

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Self-checking bench for ps2_keyboard_tx: a line monitor decodes frames, vectors check bytes and timing.
module tb_ps2_keyboard_tx;

    localparam int CLK_DIV  = 4;
    localparam int GAP      = 8;
    localparam int SEQ_CYC  = 22 * CLK_DIV + GAP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_ascii = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, ps2_clk, ps2_data, busy, err;

    ps2_keyboard_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_ascii (in_ascii),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Line monitor: acts as a PS/2 host, sampling data on each falling ps2_clk.
    logic [10:0] frames[$];
    int          err_cnt = 0;
    int          low_cnt = 0;
    int          nbits   = 0;
    logic        prev_clk = 1'b1;
    logic [10:0] sh = '0;

    always @(negedge clk) begin
        if (rst) begin
            nbits    = 0;
            prev_clk = 1'b1;
        end else begin
            if (err) err_cnt++;
            if (!ps2_clk || !ps2_data) low_cnt++;
            if (prev_clk && !ps2_clk) begin
                sh[nbits] = ps2_data;
                nbits++;
                if (nbits == 11) begin
                    frames.push_back(sh);
                    nbits = 0;
                end
            end
            prev_clk = ps2_clk;
        end
    end

    typedef struct {
        logic [7:0] ascii;
        bit         mapped;
        bit         shifted;
        logic [7:0] code;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    function automatic logic [7:0] exp_byte(input vec_t v, input int i);
        logic [7:0] seq3[3];
        logic [7:0] seq6[6];
        seq3 = '{v.code, 8'hF0, v.code};
        seq6 = '{8'h12, v.code, 8'hF0, v.code, 8'hF0, 8'h12};
        return v.shifted ? seq6[i] : seq3[i % 3];
    endfunction

    function automatic logic [7:0] decode(input logic [7:0] c);
        case (c)
            8'h33:   return 8'h68;
            8'h24:   return 8'h65;
            8'h4B:   return 8'h6C;
            8'h44:   return 8'h6F;
            8'h29:   return 8'h20;
            8'h45:   return 8'h30;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int frame_ok(input logic [10:0] f);
        return (f[0] == 1'b0 && f[10] == 1'b1 && (^f[9:1]) == 1'b1) ? 1 : 0;
    endfunction

    // Sends one character; returns busy-cycle count and cycle (1 = first after accept) of err.
    task automatic send(input logic [7:0] ch, output int bcyc, output int err_pos);
        int w;
        @(negedge clk);
        in_ascii = ch;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", (w < 1000) ? 1 : 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        bcyc    = 0;
        err_pos = -1;
        for (int c = 1; c < 2000; c++) begin
            @(negedge clk);
            if (!busy) break;
            bcyc++;
            if (err && err_pos < 0) err_pos = c;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcyc, epos, e0, l0, n, c;
        logic [7:0] dec[$];
        logic [7:0] hello[7];

        vecs[0]  = '{8'h61, 1'b1, 1'b0, 8'h1C};
        vecs[1]  = '{8'h7B, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{8'h20, 1'b1, 1'b0, 8'h29};
        vecs[3]  = '{8'h30, 1'b1, 1'b0, 8'h45};
        vecs[4]  = '{8'h39, 1'b1, 1'b0, 8'h46};
        vecs[5]  = '{8'h7A, 1'b1, 1'b0, 8'h1A};
        vecs[6]  = '{8'h6D, 1'b1, 1'b0, 8'h3A};
        vecs[7]  = '{8'h00, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{8'h60, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{8'h2F, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{8'h3A, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{8'h40, 1'b0, 1'b0, 8'h00};
        vecs[14] = '{8'h5B, 1'b0, 1'b0, 8'h00};
`ifdef PS2_TX_SHIFT_EN
        vecs[11] = '{8'h51, 1'b1, 1'b1, 8'h15};
        vecs[12] = '{8'h41, 1'b1, 1'b1, 8'h1C};
`else
        vecs[11] = '{8'h51, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{8'h41, 1'b0, 1'b0, 8'h00};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_ps2_clk", ps2_clk, 1);
        check("rst_ps2_data", ps2_data, 1);
        rst = 1'b0;

        // 'a': exact bit patterns of the make and break frames
        frames.delete();
        e0 = err_cnt;
        send(8'h61, bcyc, epos);
        check("a_nframes", frames.size(), 3);
        if (frames.size() >= 2) begin
            check("a_frame0_bits", frames[0], 11'h438);
            check("a_frame1_bits", frames[1], 11'h7E0);
            check("a_f0_parity", frames[1][9], 1);
        end
        check("a_busy_cyc", bcyc, 1 + 3 * SEQ_CYC);
        check("a_err_none", err_cnt - e0, 0);

        // Table-driven vectors
        for (int k = 0; k < NV; k++) begin
            frames.delete();
            e0 = err_cnt;
            l0 = low_cnt;
            send(vecs[k].ascii, bcyc, epos);
            n = !vecs[k].mapped ? 0 : (vecs[k].shifted ? 6 : 3);
            check($sformatf("v%0d_nframes", k), frames.size(), n);
            for (int i = 0; i < n && i < frames.size(); i++) begin
                check($sformatf("v%0d_byte%0d", k, i), frames[i][8:1], exp_byte(vecs[k], i));
                check($sformatf("v%0d_framing%0d", k, i), frame_ok(frames[i]), 1);
            end
            check($sformatf("v%0d_busy_cyc", k), bcyc, vecs[k].mapped ? 1 + n * SEQ_CYC : 2);
            check($sformatf("v%0d_err_cnt", k), err_cnt - e0, vecs[k].mapped ? 0 : 1);
            if (!vecs[k].mapped) begin
                check($sformatf("v%0d_err_pos", k), epos, 2);
                check($sformatf("v%0d_line_low", k), low_cnt - l0, 0);
            end
        end

        // Back-to-back: '1' then '2' with in_valid held
        frames.delete();
        @(negedge clk);
        in_ascii = 8'h31;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_ascii = 8'h32;
        c = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
            c++;
        end
        check("b2b_busy1", c, 1 + 3 * SEQ_CYC);
        check("b2b_ready_idle", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("b2b_no_extra_idle", busy, 1);
        c = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) break;
            c++;
        end
        check("b2b_busy2", c, 1 + 3 * SEQ_CYC);
        check("b2b_nframes", frames.size(), 6);
        if (frames.size() == 6) begin
            check("b2b_b0", frames[0][8:1], 8'h16);
            check("b2b_b1", frames[1][8:1], 8'hF0);
            check("b2b_b2", frames[2][8:1], 8'h16);
            check("b2b_b3", frames[3][8:1], 8'h1E);
            check("b2b_b4", frames[4][8:1], 8'hF0);
            check("b2b_b5", frames[5][8:1], 8'h1E);
        end

        // Reset during bit 5 of the 0xF0 frame
        frames.delete();
        @(negedge clk);
        in_ascii = 8'h61;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (140) @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_frames_done", frames.size(), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ps2_clk", ps2_clk, 1);
        check("mid_rst_ps2_data", ps2_data, 1);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        frames.delete();
        send(8'h7A, bcyc, epos);
        check("post_rst_nframes", frames.size(), 3);
        if (frames.size() == 3) begin
            check("post_rst_b0", frames[0][8:1], 8'h1A);
            check("post_rst_b1", frames[1][8:1], 8'hF0);
            check("post_rst_b2", frames[2][8:1], 8'h1A);
            check("post_rst_framing", frame_ok(frames[0]) & frame_ok(frames[1]) & frame_ok(frames[2]), 1);
        end
        check("post_rst_busy_cyc", bcyc, 1 + 3 * SEQ_CYC);

        // Loopback decode of "hello 0"
        hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h30};
        frames.delete();
        for (int i = 0; i < 7; i++) send(hello[i], bcyc, epos);
        for (int i = 0; i < frames.size(); i++) begin
            if (frames[i][8:1] == 8'hF0) i++;
            else dec.push_back(decode(frames[i][8:1]));
        end
        check("loop_count", dec.size(), 7);
        for (int i = 0; i < 7 && i < dec.size(); i++)
            check($sformatf("loop_char%0d", i), dec[i], hello[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
